// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the serial BCD ALU
package bcd_pkg;

    typedef enum logic [1:0] {REPOSO, CALCULO, ENTREGA} estado_t;

    localparam logic       MODO_SUMA  = 1'b0;
    localparam logic       MODO_RESTA = 1'b1;
    localparam logic [3:0] BCD_MAX    = 4'd9;

endpackage

// File: rtl/bcd_alu_serial_if.sv
// rtl/bcd_alu_serial_if.sv - operand/result handshake bundle for bcd_alu_serial
interface bcd_alu_serial_if #(
    parameter int DIGITOS = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [4*DIGITOS-1:0]   operando_a;
    logic [4*DIGITOS-1:0]   operando_b;
    logic                   modo;
    logic                   out_valid;
    logic                   out_ready;
    logic [4*DIGITOS-1:0]   resultado;
    logic                   acarreo;
    logic                   error;

    modport master (
        output in_valid, operando_a, operando_b, modo, out_ready,
        input  in_ready, out_valid, resultado, acarreo, error
    );

    modport slave (
        input  in_valid, operando_a, operando_b, modo, out_ready,
        output in_ready, out_valid, resultado, acarreo, error
    );
endinterface

// File: rtl/bcd_digito.sv
// rtl/bcd_digito.sv - one-digit combinational BCD add/subtract cell
module bcd_digito
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       modo,
    input  logic       cin,
    output logic [3:0] digito,
    output logic       cout,
    output logic       invalido
);

    logic [4:0] suma;
    logic [5:0] resta;

    always_comb begin
        suma     = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        resta    = {2'b0, a} - {2'b0, b} - {5'b0, cin};
        invalido = (a > BCD_MAX) || (b > BCD_MAX);
        if (modo == MODO_SUMA) begin
            cout   = (suma > 5'd9);
            digito = cout ? 4'(suma - 5'd10) : suma[3:0];
        end else begin
            // resta[5] is the sign of the two's-complement difference: a borrow
            cout   = resta[5];
            digito = cout ? 4'(resta + 6'd10) : resta[3:0];
        end
    end

endmodule

// File: rtl/bcd_alu_serial.sv
// rtl/bcd_alu_serial.sv - digit-serial BCD add/subtract unit, LSD first
module bcd_alu_serial
    import bcd_pkg::*;
#(
    parameter int DIGITOS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    bcd_alu_serial_if.slave   bus
);

    localparam int                IDX_W    = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITOS - 1);

    estado_t              estado, estado_sig;
    logic [4*DIGITOS-1:0] a_q, b_q, res_q;
    logic                 modo_q, carry_q, err_q;
    logic [IDX_W-1:0]     idx;
    logic [3:0]           a_dig, b_dig, dig;
    logic                 cout, invalido;

    assign a_dig = a_q[4*idx +: 4];
    assign b_dig = b_q[4*idx +: 4];

    bcd_digito u_digito (
        .a        (a_dig),
        .b        (b_dig),
        .modo     (modo_q),
        .cin      (carry_q),
        .digito   (dig),
        .cout     (cout),
        .invalido (invalido)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) estado <= REPOSO;
        else        estado <= estado_sig;
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            REPOSO:  if (bus.in_valid)      estado_sig = CALCULO;
            CALCULO: if (idx == IDX_LAST)   estado_sig = ENTREGA;
            ENTREGA: if (bus.out_ready)     estado_sig = REPOSO;
            default:                        estado_sig = REPOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            modo_q  <= MODO_SUMA;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            idx     <= '0;
        end else begin
            case (estado)
                REPOSO: if (bus.in_valid) begin
                    a_q     <= bus.operando_a;
                    b_q     <= bus.operando_b;
                    modo_q  <= bus.modo;
                    carry_q <= 1'b0;
                    err_q   <= 1'b0;
                    idx     <= '0;
                end
                CALCULO: begin
                    res_q[4*idx +: 4] <= dig;
                    carry_q           <= cout;
                    err_q             <= err_q | invalido;
                    idx               <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // An invalid operand digit makes the arithmetic meaningless, so mask it out
    assign bus.in_ready  = (estado == REPOSO);
    assign bus.out_valid = (estado == ENTREGA);
    assign bus.resultado = err_q ? '0 : res_q;
    assign bus.acarreo   = carry_q & ~err_q;
    assign bus.error     = err_q;

endmodule

// File: tb/tb_bcd_alu_serial.sv
// tb/tb_bcd_alu_serial.sv - randomized self-checking bench for bcd_alu_serial
module tb_bcd_alu_serial;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_alu_serial_if #(.DIGITOS(4)) bus4();
    bcd_alu_serial_if #(.DIGITOS(1)) bus1();

    bcd_alu_serial #(.DIGITOS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    bcd_alu_serial #(.DIGITOS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    logic [1:0]  iv = 2'b00;
    logic [1:0]  ordy = 2'b00;
    logic [15:0] op_a = '0, op_b = '0;
    logic        op_m = 1'b0;

    assign bus4.in_valid   = iv[0];
    assign bus4.operando_a = op_a;
    assign bus4.operando_b = op_b;
    assign bus4.modo       = op_m;
    assign bus4.out_ready  = ordy[0];
    assign bus1.in_valid   = iv[1];
    assign bus1.operando_a = op_a[3:0];
    assign bus1.operando_b = op_b[3:0];
    assign bus1.modo       = op_m;
    assign bus1.out_ready  = ordy[1];

    logic [1:0]  rdy, ov, cy, er;
    logic [15:0] res4, res1;
    assign rdy  = {bus1.in_ready,  bus4.in_ready};
    assign ov   = {bus1.out_valid, bus4.out_valid};
    assign cy   = {bus1.acarreo,   bus4.acarreo};
    assign er   = {bus1.error,     bus4.error};
    assign res4 = bus4.resultado;
    assign res1 = {12'b0, bus1.resultado};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: decimal arithmetic modulo 10^n on the operand values
    function automatic void model(input int n, input logic [15:0] a, input logic [15:0] b,
                                  input logic m, output logic [15:0] r,
                                  output logic c, output logic e);
        int va = 0, vb = 0, p = 1, v;
        e = 1'b0;
        for (int k = n - 1; k >= 0; k--) begin
            if (a[4*k +: 4] > 9 || b[4*k +: 4] > 9) e = 1'b1;
            va = va * 10 + int'(a[4*k +: 4]);
            vb = vb * 10 + int'(b[4*k +: 4]);
        end
        for (int k = 0; k < n; k++) p = p * 10;
        v = m ? va - vb : va + vb;
        c = 1'b0;
        if (v < 0)       begin v = v + p; c = 1'b1; end
        else if (v >= p) begin v = v - p; c = 1'b1; end
        r = '0;
        for (int k = 0; k < n; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        if (e) begin r = '0; c = 1'b0; end
    endfunction

    function automatic logic [15:0] rand_bcd(input bit allow_bad);
        logic [15:0] v;
        for (int k = 0; k < 4; k++) begin
            v[4*k +: 4] = 4'($urandom_range(0, 9));
            if (allow_bad && $urandom_range(0, 9) == 0) v[4*k +: 4] = 4'($urandom_range(10, 15));
        end
        return v;
    endfunction

    logic [15:0] exp_r;
    logic        exp_c, exp_e;

    task automatic start_op(input string tag, input int sel, input logic [15:0] a,
                            input logic [15:0] b, input logic m, output int waited);
        int lat = 0;
        int n = (sel == 1) ? 1 : 4;
        waited = 0;
        while (!rdy[sel] && waited < 50) begin @(posedge clk); #1; waited++; end
        check({tag, " in_ready"}, 32'(rdy[sel]), 1);
        op_a = a; op_b = b; op_m = m; iv[sel] = 1'b1;
        @(posedge clk); #1;
        iv[sel] = 1'b0;
        while (!ov[sel] && lat < 20) begin @(posedge clk); #1; lat++; end
        check({tag, " latency"}, lat, n);
        model(n, a, b, m, exp_r, exp_c, exp_e);
        check({tag, " resultado"}, (sel == 1) ? res1 : res4, exp_r);
        check({tag, " acarreo"},   32'(cy[sel]), 32'(exp_c));
        check({tag, " error"},     32'(er[sel]), 32'(exp_e));
    endtask

    task automatic finish_op(input string tag, input int sel);
        ordy[sel] = 1'b1;
        @(posedge clk); #1;
        ordy[sel] = 1'b0;
        check({tag, " out_valid_drop"}, 32'(ov[sel]), 0);
        check({tag, " in_ready_back"},  32'(rdy[sel]), 1);
    endtask

    task automatic do_op(input string tag, input int sel, input logic [15:0] a,
                         input logic [15:0] b, input logic m);
        int w;
        start_op(tag, sel, a, b, m, w);
        finish_op(tag, sel);
    endtask

    task automatic check_reset_values(input string tag, input int sel);
        check({tag, " rst in_ready"},  32'(rdy[sel]), 1);
        check({tag, " rst out_valid"}, 32'(ov[sel]), 0);
        check({tag, " rst resultado"}, (sel == 1) ? res1 : res4, 0);
        check({tag, " rst acarreo"},   32'(cy[sel]), 0);
        check({tag, " rst error"},     32'(er[sel]), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int w;
        logic [15:0] held;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("d4", 0);
        check_reset_values("d1", 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("add 0999+0001", 0, 16'h0999, 16'h0001, 1'b0);
        do_op("add 9999+0001", 0, 16'h9999, 16'h0001, 1'b0);
        do_op("sub 0100-0001", 0, 16'h0100, 16'h0001, 1'b1);
        do_op("sub 0001-0002", 0, 16'h0001, 16'h0002, 1'b1);
        do_op("err 12A4",      0, 16'h12A4, 16'h0003, 1'b0);

        // Stall the consumer while the producer keeps offering new operands
        start_op("hold", 0, 16'h4321, 16'h1234, 1'b0, w);
        held = exp_r;
        for (int i = 0; i < 5; i++) begin
            op_a = rand_bcd(0); op_b = rand_bcd(0); op_m = 1'(i); iv[0] = 1'b1;
            @(posedge clk); #1;
            check("hold out_valid", 32'(ov[0]), 1);
            check("hold in_ready",  32'(rdy[0]), 0);
            check("hold resultado", res4, held);
        end
        iv[0] = 1'b0;
        finish_op("hold", 0);
        start_op("after hold", 0, 16'h0250, 16'h0750, 1'b0, w);
        check("after hold accept delay", w, 0);
        finish_op("after hold", 0);

        // Abort in the second digit cycle
        op_a = 16'h1234; op_b = 16'h5678; op_m = 1'b0; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("midcalc", 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        start_op("add 0005+0005", 0, 16'h0005, 16'h0005, 1'b0, w);
        check("add 0005+0005 literal", res4, 16'h0010);
        finish_op("add 0005+0005", 0);

        for (int i = 0; i < 30; i++)
            do_op("rand4", 0, rand_bcd(1), rand_bcd(1), 1'($urandom_range(0, 1)));

        do_op("d1 7+5", 1, 16'h0007, 16'h0005, 1'b0);
        check("d1 7+5 literal acarreo", 32'(exp_c), 1);
        for (int i = 0; i < 10; i++)
            do_op("rand1", 1, rand_bcd(1), rand_bcd(1), 1'($urandom_range(0, 1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
